// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// Holds the FSM state enum, register map and frame length.
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/spi_reg_ctrl_sync.sv
// Multi-flop synchronizer for one async input, plus one
// extra flop holding the previous synced value for edge detect.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_d
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      q_d  <= 1'b0;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      q_d <= sync[STAGES-1];
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI (mode 0) write-only register block: 16-bit frames,
// R/W + 7-bit address + 8-bit data, five control registers.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter logic [6:0] MAX_ADDR    = 7'h04,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic [7:0] en_out_lo,
  output logic [7:0] en_out_hi,
  output logic [7:0] en_pwm_lo,
  output logic [7:0] en_pwm_hi,
  output logic [7:0] pwm_duty,
  output logic       txn_done
);

  logic ncs_q, ncs_d;
  logic sclk_q, sclk_d;
  logic copi_q, copi_unused;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs),
    .q(ncs_q), .q_d(ncs_d)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(sclk_q), .q_d(sclk_d)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi),
    .q(copi_q), .q_d(copi_unused)
  );

  logic sclk_rise, ncs_fall, ncs_rise;

  assign sclk_rise = sclk_q & ~sclk_d;
  assign ncs_fall  = ~ncs_q & ncs_d;
  assign ncs_rise  = ncs_q & ~ncs_d;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [15:0] sh;
  logic        full;
  logic        wr_ok;

  assign full  = (cnt == 5'(FRAME_BITS));
  assign wr_ok = (state == COMMIT) && sh[15]
               && (sh[14:8] <= MAX_ADDR);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ncs_fall) state_nx = SHIFT;
      end
      SHIFT: begin
        if (ncs_rise) state_nx = full ? COMMIT : IDLE;
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (state == IDLE && ncs_fall) begin
      cnt <= '0;
      sh  <= '0;
    end else if (state == SHIFT && sclk_rise && !full) begin
      sh  <= {sh[14:0], copi_q};
      cnt <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_lo <= '0;
      en_out_hi <= '0;
      en_pwm_lo <= '0;
      en_pwm_hi <= '0;
      pwm_duty  <= '0;
    end else if (wr_ok) begin
      case (sh[14:8])
        ADDR_EN_OUT_LO: en_out_lo <= sh[7:0];
        ADDR_EN_OUT_HI: en_out_hi <= sh[7:0];
        ADDR_EN_PWM_LO: en_pwm_lo <= sh[7:0];
        ADDR_EN_PWM_HI: en_pwm_hi <= sh[7:0];
        ADDR_PWM_DUTY:  pwm_duty  <= sh[7:0];
        default: ;
      endcase
    end
  end

  assign txn_done = wr_ok;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed table,
// reset-mid-frame sequence and random frames vs a register model.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ncs = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty;
  logic       txn_done;

  spi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
    .en_out_lo(en_out_lo), .en_out_hi(en_out_hi),
    .en_pwm_lo(en_pwm_lo), .en_pwm_hi(en_pwm_hi),
    .pwm_duty(pwm_duty), .txn_done(txn_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (txn_done) done_cnt = done_cnt + 1;
  end

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [39:0] exp_regs;
    int          exp_done;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] model[5];

  function automatic logic [39:0] dut_regs();
    return {pwm_duty, en_pwm_hi, en_pwm_lo, en_out_hi, en_out_lo};
  endfunction

  function automatic logic [39:0] model_regs();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic check_regs(input string name, input logic [39:0] exp);
    logic [39:0] act;
    act = dut_regs();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s regs got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_done(input string name, input int exp);
    tests++;
    if (done_cnt != exp) begin
      fails++;
      $display("FAIL %s txn_done pulses got %0d expected %0d",
               name, done_cnt, exp);
    end
  endtask

  // sclk = clk/10: 50 ns low, 50 ns high per bit
  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      copi = bits[31-i];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    done_cnt = 0;
    ncs = 1'b0;
    #100;
    shift_bits(bits, n);
    #50 ncs = 1'b1;
    #150;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{{16'h80F0, 16'hFFFF}, 16, 40'h00_00_00_00_F0, 1};
    vecs[1] = '{{16'h8480, 16'hFFFF}, 16, 40'h80_00_00_00_F0, 1};
    vecs[2] = '{{16'h8400, 16'hFFFF}, 16, 40'h00_00_00_00_F0, 1};
    vecs[3] = '{{16'h90AA, 16'hFFFF}, 16, 40'h00_00_00_00_F0, 0};
    vecs[4] = '{{16'h0055, 16'hFFFF}, 16, 40'h00_00_00_00_F0, 0};
    vecs[5] = '{{16'h82FF, 16'hFFFF}, 12, 40'h00_00_00_00_F0, 0};
    vecs[6] = '{{16'h820F, 16'hFFFF}, 16, 40'h00_00_0F_00_F0, 1};
    vecs[7] = '{{16'h833C, 16'hFFFF}, 20, 40'h00_3C_0F_00_F0, 1};

    #23;
    @(negedge clk);
    check_regs("reset_regs", 40'h0);
    tests++;
    if (txn_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done got %b expected 0", txn_done);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].bits, vecs[i].nbits);
      check_regs($sformatf("vec%0d", i), vecs[i].exp_regs);
      check_done($sformatf("vec%0d", i), vecs[i].exp_done);
    end

    // reset in the middle of a frame
    ncs = 1'b0;
    #100;
    shift_bits({16'h8155, 16'h0}, 8);
    #20 rst_n = 1'b0;
    #3;
    check_regs("async_reset", 40'h0);
    ncs = 1'b1;
    #40 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send({16'h8101, 16'h0}, 16);
    check_regs("after_reset", 40'h00_00_00_01_00);
    check_done("after_reset", 1);

    for (int k = 0; k < 5; k++) model[k] = 8'h00;
    model[1] = 8'h01;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] bits;
      logic [6:0]  addr;
      int          n, exp_d, sel;
      bits = $urandom;
      if ($urandom_range(0, 4) != 0) bits[30:24] = 7'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = $urandom_range(1, 15);
      else if (sel == 1) n = $urandom_range(17, 20);
      else               n = 16;
      addr  = bits[30:24];
      exp_d = 0;
      if (n >= 16 && bits[31] && addr <= 7'd4) begin
        model[addr] = bits[23:16];
        exp_d = 1;
      end
      send(bits, n);
      check_regs($sformatf("rand%0d", i), model_regs());
      check_done($sformatf("rand%0d", i), exp_d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 7'h04, highest writable register address.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on every SPI input.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ncs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port sclk  input  1  SPI clock (mode 0), asynchronous to clk.
REQ-007 SHALL have port copi  input  1  SPI data in, MSB first.
REQ-008 SHALL have port en_out_lo  output  8  register 0x00, output enables [7:0].
REQ-009 SHALL have port en_out_hi  output  8  register 0x01, output enables [15:8].
REQ-010 SHALL have port en_pwm_lo  output  8  register 0x02, PWM mode [7:0].
REQ-011 SHALL have port en_pwm_hi  output  8  register 0x03, PWM mode [15:8].
REQ-012 SHALL have port pwm_duty  output  8  register 0x04, PWM duty cycle.
REQ-013 SHALL have port txn_done  output  1  one-clk pulse per committed write.

Function
REQ-014 ncs, sclk, copi SHALL each pass through a SYNC_STAGES-flop synchronizer before any use.
REQ-015 Edge detection SHALL use one extra flop per signal: sclk rise, ncs fall, ncs rise.
REQ-016 FSM states: IDLE, SHIFT, COMMIT.
REQ-017 IDLE -> SHIFT on ncs fall; bit counter (5 bits) and 16-bit shift register cleared.
REQ-018 In SHIFT each synced sclk rise SHALL shift copi into bit 0; counter increments, saturating at 16; bits after the 16th ignored.
REQ-019 SHIFT -> COMMIT on ncs rise when counter==16; SHIFT -> IDLE (frame discarded, no register change) when counter<16.
REQ-020 Frame format: bit15 = R/W (1=write), bits14:8 = address, bits7:0 = data.
REQ-021 COMMIT SHALL, in one clk, write data to the addressed register iff bit15==1 and address<=MAX_ADDR, pulse txn_done in that same cycle, then return to IDLE.
REQ-022 Reads (bit15==0) and addresses >MAX_ADDR SHALL be dropped silently: no register change, no txn_done.
REQ-023 Updated register value SHALL be visible on outputs the clk after the COMMIT cycle.
REQ-024 ncs fall and rise detected in the same cycle is impossible by construction; an ncs fall in COMMIT SHALL be ignored (IDLE re-entered first).
REQ-025 sclk edges while ncs high SHALL have no effect.

Reset
REQ-026 rst_n low SHALL asynchronously clear all five registers to 8'h00, txn_done to 0, FSM to IDLE, counter, shift register and synchronizer flops to 0.
REQ-027 Reset mid-frame SHALL abandon the frame; the next frame after release decodes normally.

Structure
REQ-028 Shared package SHALL hold FSM state enum, register address constants ADDR_EN_OUT_LO..ADDR_PWM_DUTY, and FRAME_BITS=16.
REQ-029 One sub-module, spi_sync, SHALL implement the parameterized synchronizer plus edge-detect flop, instantiated three times.

Verification
REQ-030 Write 0x80 0xF0 (addr 0x00, data 0xF0), sclk = clk/10 -> en_out_lo=0xF0 and one txn_done pulse; others 0x00.
REQ-031 Write 0x84 0x80 -> pwm_duty=0x80; then 0x84 0x00 -> pwm_duty=0x00.
REQ-032 Write 0x90 0xAA (addr 0x10) and read frame 0x00 0x55 -> all registers unchanged, no txn_done.
REQ-033 ncs raised after 12 bits of 0x82 0xFF -> en_pwm_lo stays 0x00; following full frame 0x82 0x0F -> 0x0F.
REQ-034 20 sclk edges with bits 0x83 0x3C then 4 extra ones -> en_pwm_hi=0x3C.
REQ-035 rst_n asserted after 8 bits of a frame, released, then 0x81 0x01 -> en_out_hi=0x01, all other registers 0x00.
